// File: rtl/pong_ball_engine.sv
// -----------------------------------------------------------------------------
// pong_ball_engine
// Ball/paddle engine for the ping-pong LED game. Owns ball position,
// direction, rally state and both scores, and drives the LED bar directly.
//
// Ports:
//   clk_game  in   game clock, all logic on the rising edge
//   reset     in   synchronous active-high reset
//   tick      in   single-cycle ball-step enable
//   btn_l     in   left player button (debounced, synchronised, level)
//   btn_r     in   right player button (debounced, synchronised, level)
//   led       out  LED bar, bit 0 = right end, bit N_LED-1 = left end
//   score_l   out  left player score
//   score_r   out  right player score
//   ball_dir  out  1 = moving left (pos increasing), 0 = moving right
//   game_over out  high once a player has won
// -----------------------------------------------------------------------------
module pong_ball_engine #(
   parameter int N_LED      = 16,
   parameter int HIT_WIN    = 1,
   parameter int MISS_TICKS = 4,
   parameter int MAX_SCORE  = 7,
   parameter int SCORE_W    = 3
) (
   input  logic               clk_game,
   input  logic               reset,
   input  logic               tick,
   input  logic               btn_l,
   input  logic               btn_r,
   output logic [N_LED-1:0]   led,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               ball_dir,
   output logic               game_over
);

   localparam int PW = $clog2(N_LED);
   localparam int MW = $clog2(MISS_TICKS + 1);

   localparam logic [PW-1:0]      POS_ZERO   = PW'(0);
   localparam logic [PW-1:0]      POS_ONE    = PW'(1);
   localparam logic [PW-1:0]      POS_MAX    = PW'(N_LED - 1);
   localparam logic [PW-1:0]      HIT_L_MIN  = PW'(N_LED - HIT_WIN);
   localparam logic [PW-1:0]      HIT_R_MAX  = PW'(HIT_WIN - 1);
   localparam logic [MW-1:0]      MISS_ZERO  = MW'(0);
   localparam logic [MW-1:0]      MISS_ONE   = MW'(1);
   localparam logic [MW-1:0]      MISS_LOAD  = MW'(MISS_TICKS);
   localparam logic [SCORE_W-1:0] SCORE_ZERO = SCORE_W'(0);
   localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);
   localparam logic [N_LED-1:0]   LED_ONE    = N_LED'(1);
   localparam logic [N_LED-1:0]   LED_ZERO   = N_LED'(0);
   localparam logic [N_LED-1:0]   LED_LEFT   = {1'b1, {(N_LED-1){1'b0}}};

   // Miss pattern: bits 3..N_LED-4 lit, both ends dark.
   function automatic logic [N_LED-1:0] miss_pat_f();
      logic [N_LED-1:0] p;
      for (int i = 0; i < N_LED; i++) begin
         if (i >= 3 && i <= N_LED - 4) begin
            p[i] = 1'b1;
         end else begin
            p[i] = 1'b0;
         end
      end
      return p;
   endfunction

   // Game-over pattern: miss pattern with a gap in the middle.
   function automatic logic [N_LED-1:0] over_pat_f();
      logic [N_LED-1:0] p;
      p = miss_pat_f();
      p[N_LED/2 - 1] = 1'b0;
      p[N_LED/2]     = 1'b0;
      return p;
   endfunction

   localparam logic [N_LED-1:0] MISS_PAT = miss_pat_f();
   localparam logic [N_LED-1:0] OVER_PAT = over_pat_f();

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_RUN   = 2'd1,
      ST_MISS  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic                 server_l_r, server_l_s;   // 1 = left player serves
   logic [PW-1:0]        pos_r, pos_s;
   logic [MW-1:0]        miss_cnt_r, miss_cnt_s;
   logic                 btn_l_q_r, btn_r_q_r;
   logic                 dir_s;
   logic [SCORE_W-1:0]   score_l_s, score_r_s;
   logic [N_LED-1:0]     led_s;
   logic                 game_over_s;
   logic                 press_l_s, press_r_s;
   logic                 hit_l_s, hit_r_s;

   assign press_l_s = btn_l & ~btn_l_q_r;
   assign press_r_s = btn_r & ~btn_r_q_r;

   // Only the receiving player, inside the hit window, can return the ball.
   assign hit_l_s = ball_dir  & press_l_s & (pos_r >= HIT_L_MIN);
   assign hit_r_s = ~ball_dir & press_r_s & (pos_r <= HIT_R_MAX);

   // Next-state logic for rally FSM, position, direction, scores and LEDs.
   always_comb begin
      state_s     = state_r;
      server_l_s  = server_l_r;
      pos_s       = pos_r;
      miss_cnt_s  = miss_cnt_r;
      dir_s       = ball_dir;
      score_l_s   = score_l;
      score_r_s   = score_r;

      case (state_r)
         ST_SERVE: begin
            if (server_l_r && press_l_s) begin
               state_s = ST_RUN;
               dir_s   = 1'b0;
            end else if (!server_l_r && press_r_s) begin
               state_s = ST_RUN;
               dir_s   = 1'b1;
            end else begin
               state_s = ST_SERVE;
            end
         end
         ST_RUN: begin
            if (hit_l_s || hit_r_s) begin
               // A hit beats a coincident tick; the step uses the new direction.
               dir_s = ~ball_dir;
               if (tick) begin
                  pos_s = ball_dir ? (pos_r - POS_ONE) : (pos_r + POS_ONE);
               end else begin
                  pos_s = pos_r;
               end
            end else if (tick) begin
               if (ball_dir && (pos_r == POS_MAX)) begin
                  score_r_s  = score_r + SCORE_ONE;
                  server_l_s = 1'b1;
                  miss_cnt_s = MISS_LOAD;
                  state_s    = ST_MISS;
               end else if (!ball_dir && (pos_r == POS_ZERO)) begin
                  score_l_s  = score_l + SCORE_ONE;
                  server_l_s = 1'b0;
                  miss_cnt_s = MISS_LOAD;
                  state_s    = ST_MISS;
               end else if (ball_dir) begin
                  pos_s = pos_r + POS_ONE;
               end else begin
                  pos_s = pos_r - POS_ONE;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_MISS: begin
            if (tick) begin
               if (miss_cnt_r == MISS_ONE) begin
                  miss_cnt_s = MISS_ZERO;
                  // The server is the player who lost, so the scorer is the other one.
                  if ((server_l_r ? score_r : score_l) == SCORE_MAX) begin
                     state_s = ST_OVER;
                  end else begin
                     state_s = ST_SERVE;
                     pos_s   = server_l_r ? POS_MAX : POS_ZERO;
                     dir_s   = 1'b0;
                  end
               end else begin
                  miss_cnt_s = miss_cnt_r - MISS_ONE;
               end
            end else begin
               state_s = ST_MISS;
            end
         end
         ST_OVER: begin
            state_s = ST_OVER;
         end
         default: begin
            state_s = ST_SERVE;
         end
      endcase

      case (state_s)
         ST_SERVE, ST_RUN: led_s = LED_ONE << pos_s;
         ST_MISS:          led_s = MISS_PAT;
         ST_OVER:          led_s = OVER_PAT;
         default:          led_s = LED_ZERO;
      endcase

      game_over_s = (state_s == ST_OVER);
   end

   // State and registered outputs; reset overrides every other input.
   always_ff @(posedge clk_game) begin
      if (reset) begin
         state_r    <= ST_SERVE;
         server_l_r <= 1'b1;
         pos_r      <= POS_MAX;
         miss_cnt_r <= MISS_ZERO;
         btn_l_q_r  <= 1'b0;
         btn_r_q_r  <= 1'b0;
         ball_dir   <= 1'b0;
         score_l    <= SCORE_ZERO;
         score_r    <= SCORE_ZERO;
         led        <= LED_LEFT;
         game_over  <= 1'b0;
      end else begin
         state_r    <= state_s;
         server_l_r <= server_l_s;
         pos_r      <= pos_s;
         miss_cnt_r <= miss_cnt_s;
         btn_l_q_r  <= btn_l;
         btn_r_q_r  <= btn_r;
         ball_dir   <= dir_s;
         score_l    <= score_l_s;
         score_r    <= score_r_s;
         led        <= led_s;
         game_over  <= game_over_s;
      end
   end

endmodule

// File: tb/tb_pong_ball_engine.sv
// -----------------------------------------------------------------------------
// tb_pong_ball_engine
// Directed bench for pong_ball_engine: a vector table for the basic rally,
// plus sequences for a full game, mid-game reset and a wider hit window.
// -----------------------------------------------------------------------------
module tb_pong_ball_engine;

   logic        clk_game = 1'b0;
   logic        reset    = 1'b1;
   logic        tick     = 1'b0;
   logic        btn_l    = 1'b0;
   logic        btn_r    = 1'b0;
   logic [15:0] led, led3;
   logic [2:0]  score_l, score_r, score_l3, score_r3;
   logic        ball_dir, game_over, ball_dir3, game_over3;

   int checks   = 0;
   int failures = 0;

   pong_ball_engine dut (
      .clk_game (clk_game),
      .reset    (reset),
      .tick     (tick),
      .btn_l    (btn_l),
      .btn_r    (btn_r),
      .led      (led),
      .score_l  (score_l),
      .score_r  (score_r),
      .ball_dir (ball_dir),
      .game_over(game_over)
   );

   pong_ball_engine #(.HIT_WIN(3)) dut3 (
      .clk_game (clk_game),
      .reset    (reset),
      .tick     (tick),
      .btn_l    (btn_l),
      .btn_r    (btn_r),
      .led      (led3),
      .score_l  (score_l3),
      .score_r  (score_r3),
      .ball_dir (ball_dir3),
      .game_over(game_over3)
   );

   // Free-running game clock.
   always #5 clk_game = ~clk_game;

   typedef struct {
      logic        bl, br, tk;
      logic [15:0] led;
      logic [2:0]  sl, sr;
      logic        dir, over;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic bl, br, tk, input logic [15:0] l,
                               input logic [2:0] sl, sr, input logic dir, over);
      vec_t v;
      v.bl = bl; v.br = br; v.tk = tk; v.led = l;
      v.sl = sl; v.sr = sr; v.dir = dir; v.over = over;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [15:0] l, input logic [2:0] sl, sr,
                          input logic dir, over);
      chk({name, ".led"},  led,       l);
      chk({name, ".sl"},   score_l,   sl);
      chk({name, ".sr"},   score_r,   sr);
      chk({name, ".dir"},  ball_dir,  dir);
      chk({name, ".over"}, game_over, over);
   endtask

   // One clock with the given inputs; outputs are stable #1 after the edge.
   task automatic cyc(input logic l, r, t);
      btn_l = l; btn_r = r; tick = t;
      @(posedge clk_game);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] w;

      // ---- vector table for the basic rally ----
      add(0,1,0, 16'h8000, 0,0, 0,0);             // right press while left serves: ignored
      add(0,0,0, 16'h8000, 0,0, 0,0);
      add(1,0,0, 16'h8000, 0,0, 0,0);             // left serves
      add(0,0,0, 16'h8000, 0,0, 0,0);
      for (int i = 0; i < 15; i++) begin
         w = 16'h4000 >> i;
         add(0,0,1, w, 0,0, 0,0);
      end
      add(0,1,0, 16'h0001, 0,0, 1,0);             // right returns at pos 0, no tick
      add(0,0,1, 16'h0002, 0,0, 1,0);
      for (int i = 0; i < 14; i++) begin
         w = 16'h0004 << i;
         add(0,0,1, w, 0,0, 1,0);
      end
      add(1,0,0, 16'h8000, 0,0, 0,0);             // left returns at pos 15
      add(0,0,0, 16'h8000, 0,0, 0,0);
      for (int i = 0; i < 15; i++) begin
         w = 16'h4000 >> i;
         add(0,0,1, w, 0,0, 0,0);
      end
      add(0,1,1, 16'h0002, 0,0, 1,0);             // hit and tick together
      add(0,0,0, 16'h0002, 0,0, 1,0);
      for (int i = 0; i < 14; i++) begin
         w = 16'h0004 << i;
         add(0,0,1, w, 0,0, 1,0);
      end
      add(0,0,1, 16'h1FF8, 0,1, 1,0);             // left misses, right scores
      add(0,0,0, 16'h1FF8, 0,1, 1,0);
      add(0,0,1, 16'h1FF8, 0,1, 1,0);
      add(1,0,1, 16'h1FF8, 0,1, 1,0);             // press during miss ignored
      add(0,0,1, 16'h1FF8, 0,1, 1,0);
      add(0,0,1, 16'h8000, 0,1, 0,0);             // serve by left at pos 15
      add(0,1,0, 16'h8000, 0,1, 0,0);
      add(0,0,1, 16'h8000, 0,1, 0,0);             // tick ignored in serve

      do_reset();
      chk_all("reset", 16'h8000, 0, 0, 0, 0);
      for (int k = 0; k < tbl.size(); k++) begin
         cyc(tbl[k].bl, tbl[k].br, tbl[k].tk);
         chk_all($sformatf("vec%0d", k), tbl[k].led, tbl[k].sl, tbl[k].sr, tbl[k].dir, tbl[k].over);
      end

      // ---- right misses, right serves, held button gives one press ----
      do_reset();
      cyc(1,0,0); cyc(0,0,0);
      for (int i = 0; i < 15; i++) cyc(0,0,1);
      cyc(0,0,1);
      chk_all("rmiss", 16'h1FF8, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0,0,1);
      chk_all("rserve", 16'h0001, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0,1,0);
      chk_all("rhold", 16'h0001, 1, 0, 1, 0);
      cyc(0,0,1);
      chk_all("rhold_step", 16'h0002, 1, 0, 1, 0);

      // ---- left wins seven points ----
      do_reset();
      cyc(1,0,0); cyc(0,0,0);
      for (int i = 0; i < 15; i++) cyc(0,0,1);
      chk("l7_walk0", led, 16'h0001);
      for (int p = 1; p <= 7; p++) begin
         cyc(0,0,1);
         chk($sformatf("l7_sl%0d", p), score_l, p);
         chk($sformatf("l7_mled%0d", p), led, 16'h1FF8);
         for (int i = 0; i < 3; i++) cyc(0,0,1);
         chk($sformatf("l7_hold%0d", p), led, 16'h1FF8);
         cyc(0,0,1);
         if (p < 7) begin
            chk($sformatf("l7_srv%0d", p), led, 16'h0001);
            chk($sformatf("l7_ov%0d", p), game_over, 0);
            cyc(0,1,0);
            chk($sformatf("l7_dir%0d", p), ball_dir, 1);
            cyc(0,0,0);
            for (int i = 0; i < 15; i++) cyc(0,0,1);
            chk($sformatf("l7_top%0d", p), led, 16'h8000);
            cyc(1,0,0);
            chk($sformatf("l7_ret%0d", p), ball_dir, 0);
            cyc(0,0,0);
            for (int i = 0; i < 15; i++) cyc(0,0,1);
            chk($sformatf("l7_bot%0d", p), led, 16'h0001);
         end else begin
            chk_all("over", 16'h1E78, 7, 0, 0, 1);
         end
      end
      cyc(1,1,1); cyc(0,0,1); cyc(1,0,0); cyc(0,1,1);
      chk_all("over_frozen", 16'h1E78, 7, 0, 0, 1);
      do_reset();
      chk_all("over_reset", 16'h8000, 0, 0, 0, 0);

      // ---- reset mid-RUN and mid-MISS, with other inputs active ----
      cyc(1,0,0); cyc(0,0,1); cyc(0,0,1); cyc(0,0,1);
      chk("midrun_pre", led, 16'h1000);
      reset = 1'b1;
      cyc(1,1,1);
      reset = 1'b0;
      chk_all("midrun_rst", 16'h8000, 0, 0, 0, 0);
      cyc(1,0,0); cyc(0,0,0);
      for (int i = 0; i < 16; i++) cyc(0,0,1);
      chk_all("midmiss_pre", 16'h1FF8, 1, 0, 0, 0);
      reset = 1'b1;
      cyc(0,1,1);
      reset = 1'b0;
      chk_all("midmiss_rst", 16'h8000, 0, 0, 0, 0);

      // ---- HIT_WIN = 3 instance ----
      do_reset();
      cyc(1,0,0); cyc(0,0,0);
      for (int i = 0; i < 13; i++) cyc(0,0,1);
      chk("hw3_pos2", led3, 16'h0004);
      cyc(0,1,0);
      chk("hw3_hit2_dir", ball_dir3, 1);
      cyc(0,0,0);
      cyc(0,0,1);
      chk("hw3_pos3_up", led3, 16'h0008);
      for (int i = 0; i < 10; i++) cyc(0,0,1);
      chk("hw3_pos13", led3, 16'h2000);
      cyc(1,0,0);
      chk("hw3_lhit13_dir", ball_dir3, 0);
      cyc(0,0,0);
      for (int i = 0; i < 10; i++) cyc(0,0,1);
      chk("hw3_pos3_dn", led3, 16'h0008);
      cyc(0,1,0);
      chk("hw3_press3_dir", ball_dir3, 0);
      cyc(0,0,0);
      for (int i = 0; i < 3; i++) cyc(0,0,1);
      chk("hw3_pos0", led3, 16'h0001);
      cyc(0,0,1);
      chk("hw3_miss_led", led3, 16'h1FF8);
      chk("hw3_miss_sl", score_l3, 1);
      chk("hw3_miss_sr", score_r3, 0);
      chk("hw3_over", game_over3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
